// File: rtl/controle_reprodutor_if.sv
// Command pulses and player status between the pulse-generation stage,
// the playback controller and the display/audio logic.
// slave  : used by the playback controller (consumes pulses, drives status)
// master : used by whoever drives pulses and watches status
`timescale 1ns/1ps
interface controle_reprodutor_if #(
   parameter int LARGURA_FAIXA = 3,
   parameter int LARGURA_TEMPO = 8
);
   logic                     play_pulso_L;
   logic                     selecao_pulso_L;
   logic                     stop_pulso_L;
   logic                     mute_pulso_R;
   logic                     play_pulso_R;
   logic                     selecao_pulso_R;
   logic                     stop_pulso_R;
   logic [1:0]               estado;
   logic [LARGURA_FAIXA-1:0] faixa;
   logic                     mute;
   logic [LARGURA_TEMPO-1:0] tempo_seg;
   logic                     led_tocando;
   logic                     fim_faixa;

   modport master (
      output play_pulso_L, selecao_pulso_L, stop_pulso_L,
      output mute_pulso_R, play_pulso_R, selecao_pulso_R, stop_pulso_R,
      input  estado, faixa, mute, tempo_seg, led_tocando, fim_faixa
   );

   modport slave (
      input  play_pulso_L, selecao_pulso_L, stop_pulso_L,
      input  mute_pulso_R, play_pulso_R, selecao_pulso_R, stop_pulso_R,
      output estado, faixa, mute, tempo_seg, led_tocando, fim_faixa
   );
endinterface

// File: rtl/controle_reprodutor.sv
// Playback control FSM: PARADO / TOCANDO / PAUSADO, current track, mute
// flag and elapsed-seconds counter driven by single-cycle command pulses.
// Optional feature macro: AUTO_AVANCO_EN -- when defined, the track ends
// automatically after DUR_FAIXA_S seconds (advance, or stop after the last).
// All outputs are registered.
`timescale 1ns/1ps
module controle_reprodutor #(
   parameter int N_FAIXAS      = 8,
   parameter int LARGURA_FAIXA = 3,
   parameter int CLK_HZ        = 50000000,
   parameter int LARGURA_TEMPO = 8,
   parameter int DUR_FAIXA_S   = 180
) (
   input  logic                  clock_in,
   input  logic                  reset_n,
   controle_reprodutor_if.slave  bus
);

   typedef enum logic [1:0] {
      PARADO  = 2'b00,
      TOCANDO = 2'b01,
      PAUSADO = 2'b10
   } estado_t;

   localparam int LARGURA_PRESC = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
   localparam logic [LARGURA_PRESC-1:0] PRESC_MAX    = LARGURA_PRESC'(CLK_HZ - 1);
   localparam logic [LARGURA_FAIXA-1:0] FAIXA_ULTIMA = LARGURA_FAIXA'(N_FAIXAS - 1);
   localparam logic [LARGURA_TEMPO-1:0] TEMPO_SAT    = '1;
`ifdef AUTO_AVANCO_EN
   localparam logic [LARGURA_TEMPO-1:0] TEMPO_FIM    = LARGURA_TEMPO'(DUR_FAIXA_S - 1);
`endif

   // Elaboration-time sanity checks on the configuration.
   if ((1 << LARGURA_FAIXA) < N_FAIXAS) begin : g_faixa_estreita
      $error("LARGURA_FAIXA too narrow for N_FAIXAS");
   end
   if (DUR_FAIXA_S < 1 || DUR_FAIXA_S > (1 << LARGURA_TEMPO) - 1) begin : g_dur_invalida
      $error("DUR_FAIXA_S out of range for LARGURA_TEMPO");
   end

   estado_t                  estado_q, estado_d;
   logic [LARGURA_FAIXA-1:0] faixa_q, faixa_d;
   logic                     mute_q, mute_d;
   logic [LARGURA_TEMPO-1:0] tempo_q, tempo_d;
   logic [LARGURA_PRESC-1:0] presc_q, presc_d;
   logic                     led_q, led_d;
   logic                     fim_q, fim_d;

   logic                     play;
   logic                     stop;
   logic                     selecao;
   logic                     tick;
   logic [LARGURA_FAIXA-1:0] faixa_prox;

   // Merge local/remote pulses, detect the prescaler wrap, next track index.
   always_comb begin
      play       = bus.play_pulso_L    | bus.play_pulso_R;
      stop       = bus.stop_pulso_L    | bus.stop_pulso_R;
      selecao    = bus.selecao_pulso_L | bus.selecao_pulso_R;
      tick       = (presc_q == PRESC_MAX);
      faixa_prox = (faixa_q == FAIXA_ULTIMA) ? '0 : faixa_q + 1'b1;
   end

   // Next-state logic: stop > play > selecao; idle cycles in TOCANDO count time.
   always_comb begin
      estado_d = estado_q;
      faixa_d  = faixa_q;
      tempo_d  = tempo_q;
      presc_d  = presc_q;
      fim_d    = 1'b0;
      mute_d   = mute_q ^ bus.mute_pulso_R;

      case (estado_q)
         PARADO: begin
            if (stop) begin
               estado_d = PARADO;
            end else if (play) begin
               estado_d = TOCANDO;
               tempo_d  = '0;
               presc_d  = '0;
            end else if (selecao) begin
               faixa_d  = faixa_prox;
            end
         end

         TOCANDO: begin
            if (stop) begin
               estado_d = PARADO;
               tempo_d  = '0;
               presc_d  = '0;
            end else if (play) begin
               // Pause freezes prescaler; a tick due this cycle is deferred.
               estado_d = PAUSADO;
            end else if (selecao) begin
               faixa_d  = faixa_prox;
               tempo_d  = '0;
               presc_d  = '0;
            end else if (tick) begin
               presc_d  = '0;
`ifdef AUTO_AVANCO_EN
               if (tempo_q == TEMPO_FIM) begin
                  tempo_d = '0;
                  fim_d   = 1'b1;
                  if (faixa_q == FAIXA_ULTIMA) begin
                     faixa_d  = '0;
                     estado_d = PARADO;
                  end else begin
                     faixa_d  = faixa_prox;
                  end
               end else if (tempo_q != TEMPO_SAT) begin
                  tempo_d = tempo_q + 1'b1;
               end
`else
               if (tempo_q != TEMPO_SAT) begin
                  tempo_d = tempo_q + 1'b1;
               end
`endif
            end else begin
               presc_d  = presc_q + 1'b1;
            end
         end

         PAUSADO: begin
            if (stop) begin
               estado_d = PARADO;
               tempo_d  = '0;
               presc_d  = '0;
            end else if (play) begin
               estado_d = TOCANDO;
            end else if (selecao) begin
               faixa_d  = faixa_prox;
               tempo_d  = '0;
               presc_d  = '0;
            end
         end

         default: begin
            estado_d = PARADO;
            tempo_d  = '0;
            presc_d  = '0;
         end
      endcase

      led_d = (estado_d == TOCANDO);
   end

   // State register with synchronous active-low reset.
   always_ff @(posedge clock_in) begin
      if (!reset_n) begin
         estado_q <= PARADO;
         faixa_q  <= '0;
         mute_q   <= 1'b0;
         tempo_q  <= '0;
         presc_q  <= '0;
         led_q    <= 1'b0;
         fim_q    <= 1'b0;
      end else begin
         estado_q <= estado_d;
         faixa_q  <= faixa_d;
         mute_q   <= mute_d;
         tempo_q  <= tempo_d;
         presc_q  <= presc_d;
         led_q    <= led_d;
         fim_q    <= fim_d;
      end
   end

   assign bus.estado      = estado_q;
   assign bus.faixa       = faixa_q;
   assign bus.mute        = mute_q;
   assign bus.tempo_seg   = tempo_q;
   assign bus.led_tocando = led_q;
   assign bus.fim_faixa   = fim_q;

endmodule

// File: tb/tb_controle_reprodutor.sv
// Scoreboard bench for controle_reprodutor: stimulus pushes expected
// snapshots tagged with the cycle they are due; a negedge monitor pops and
// compares them. Small configuration: 4 tracks, 4 clocks per second.
`timescale 1ns/1ps
module tb_controle_reprodutor;
   localparam int N_FAIXAS      = 4;
   localparam int LARGURA_FAIXA = 2;
   localparam int CLK_HZ        = 4;
   localparam int LARGURA_TEMPO = 3;
   localparam int DUR_FAIXA_S   = 3;

   // pulse bit positions
   localparam logic [6:0] P_PL  = 7'd1;
   localparam logic [6:0] P_SL  = 7'd2;
   localparam logic [6:0] P_STL = 7'd4;
   localparam logic [6:0] P_MR  = 7'd8;
   localparam logic [6:0] P_PR  = 7'd16;
   localparam logic [6:0] P_SR  = 7'd32;
   localparam logic [6:0] P_STR = 7'd64;

   logic clk = 1'b0;
   logic reset_n;
   always #5 clk = ~clk;

   controle_reprodutor_if #(.LARGURA_FAIXA(LARGURA_FAIXA), .LARGURA_TEMPO(LARGURA_TEMPO)) bus_if ();

   controle_reprodutor #(
      .N_FAIXAS      (N_FAIXAS),
      .LARGURA_FAIXA (LARGURA_FAIXA),
      .CLK_HZ        (CLK_HZ),
      .LARGURA_TEMPO (LARGURA_TEMPO),
      .DUR_FAIXA_S   (DUR_FAIXA_S)
   ) dut (
      .clock_in (clk),
      .reset_n  (reset_n),
      .bus      (bus_if)
   );

   typedef struct {
      int         cyc;
      logic [1:0] estado;
      logic [1:0] faixa;
      logic       mute;
      logic [2:0] tempo;
      logic       led;
      logic       fim;
   } exp_t;

   exp_t  exp_q[$];
   string nome_q[$];
   int    cyc = 0;
   int    checks = 0;
   int    failures = 0;
   exp_t  mon_e;
   string mon_n;

   always @(posedge clk) cyc <= cyc + 1;

   // Monitor: compare every expectation that has come due.
   always @(negedge clk) begin
      while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
         mon_e = exp_q.pop_front();
         mon_n = nome_q.pop_front();
         checks++;
         if (mon_e.cyc != cyc) begin
            failures++;
            $display("FAIL %s: compared at cycle %0d, due at cycle %0d", mon_n, cyc, mon_e.cyc);
         end else if (bus_if.estado !== mon_e.estado || bus_if.faixa !== mon_e.faixa ||
                      bus_if.mute !== mon_e.mute || bus_if.tempo_seg !== mon_e.tempo ||
                      bus_if.led_tocando !== mon_e.led || bus_if.fim_faixa !== mon_e.fim) begin
            failures++;
            $display("FAIL %s: got estado=%b faixa=%0d mute=%b tempo=%0d led=%b fim=%b, expected estado=%b faixa=%0d mute=%b tempo=%0d led=%b fim=%b",
                     mon_n, bus_if.estado, bus_if.faixa, bus_if.mute, bus_if.tempo_seg,
                     bus_if.led_tocando, bus_if.fim_faixa, mon_e.estado, mon_e.faixa,
                     mon_e.mute, mon_e.tempo, mon_e.led, mon_e.fim);
         end else begin
            $display("ok   %s: cycle %0d estado=%b faixa=%0d mute=%b tempo=%0d led=%b fim=%b",
                     mon_n, cyc, bus_if.estado, bus_if.faixa, bus_if.mute,
                     bus_if.tempo_seg, bus_if.led_tocando, bus_if.fim_faixa);
         end
      end
   end

   task automatic esperado(input int dt, input int e, input int f, input int m,
                           input int t, input int l, input int fi, input string n);
      exp_t x;
      x.cyc    = cyc + dt;
      x.estado = 2'(e);
      x.faixa  = 2'(f);
      x.mute   = 1'(m);
      x.tempo  = 3'(t);
      x.led    = 1'(l);
      x.fim    = 1'(fi);
      exp_q.push_back(x);
      nome_q.push_back(n);
   endtask

   task automatic aplica(input logic [6:0] p);
      bus_if.play_pulso_L    = p[0];
      bus_if.selecao_pulso_L = p[1];
      bus_if.stop_pulso_L    = p[2];
      bus_if.mute_pulso_R    = p[3];
      bus_if.play_pulso_R    = p[4];
      bus_if.selecao_pulso_R = p[5];
      bus_if.stop_pulso_R    = p[6];
   endtask

   // One-cycle pulse, driven from a negedge; returns at the following negedge.
   task automatic pulso(input logic [6:0] p);
      aplica(p);
      @(negedge clk);
      aplica(7'd0);
   endtask

   initial begin
      reset_n = 1'b0;
      aplica(7'd0);
      repeat (2) @(negedge clk);
      esperado(1, 0, 0, 0, 0, 0, 0, "reset_state");
      @(negedge clk);
      reset_n = 1'b1;

      // 1: play, then count two seconds
      esperado(1, 1, 0, 0, 0, 1, 0, "t1_play_L");
      esperado(4, 1, 0, 0, 0, 1, 0, "t1_before_tick");
      esperado(5, 1, 0, 0, 1, 1, 0, "t1_tempo1");
      esperado(9, 1, 0, 0, 2, 1, 0, "t1_tempo2");
      pulso(P_PL);
      repeat (8) @(negedge clk);

      // 2: pause holds, resume counts, pause on a due tick defers it
      for (int i = 1; i <= 20; i++) esperado(i, 2, 0, 0, 2, 0, 0, "t2_pause_hold");
      pulso(P_PR);
      repeat (19) @(negedge clk);
      esperado(1, 1, 0, 0, 2, 1, 0, "t2_resume");
      esperado(4, 1, 0, 0, 2, 1, 0, "t2_before_tick");
      esperado(5, 1, 0, 0, 3, 1, 0, "t2_tempo3");
      pulso(P_PL);
      repeat (7) @(negedge clk);
      esperado(1, 2, 0, 0, 3, 0, 0, "t2_pause_on_tick");
      pulso(P_PR);
      esperado(1, 1, 0, 0, 3, 1, 0, "t2_resume_at_max");
      esperado(2, 1, 0, 0, 4, 1, 0, "t2_tick_first_cycle");
      pulso(P_PL);
      @(negedge clk);

      // 3: priority stop > play > selecao
      esperado(1, 1, 1, 0, 0, 1, 0, "t3_sel_playing");
      pulso(P_SR);
      repeat (2) @(negedge clk);
      esperado(1, 0, 1, 0, 0, 0, 0, "t3_stop_prio");
      pulso(P_STL | P_PR | P_SL);
      esperado(1, 0, 1, 0, 0, 0, 0, "t3_stop_in_parado");
      pulso(P_STR);
      esperado(1, 1, 1, 0, 0, 1, 0, "t3_play_over_sel");
      pulso(P_PL | P_SR);
      esperado(1, 0, 1, 0, 0, 0, 0, "t3_stop");
      pulso(P_STL);

      // 4: track selection with wrap, merged local+remote pair
      esperado(1, 0, 2, 0, 0, 0, 0, "t4_sel_2");
      pulso(P_SL);
      esperado(1, 0, 3, 0, 0, 0, 0, "t4_sel_3");
      pulso(P_SR);
      esperado(1, 0, 0, 0, 0, 0, 0, "t4_sel_wrap");
      pulso(P_SL);
      for (int i = 1; i <= 4; i++) begin
         esperado(1, 0, i % 4, 0, 0, 0, 0, "t4_sel_seq");
         pulso((i % 2 == 1) ? P_SL : P_SR);
      end
      esperado(1, 0, 1, 0, 0, 0, 0, "t4_pair_single");
      pulso(P_SL | P_SR);

      // 5: mute toggles, survives stop; reset overrides a command
      esperado(1, 0, 1, 1, 0, 0, 0, "t5_mute_on");
      pulso(P_MR);
      esperado(1, 0, 1, 0, 0, 0, 0, "t5_mute_off");
      pulso(P_MR);
      esperado(1, 0, 2, 0, 0, 0, 0, "t5_sel");
      pulso(P_SL);
      esperado(1, 1, 2, 0, 0, 1, 0, "t5_play");
      pulso(P_PR);
      esperado(1, 0, 2, 1, 0, 0, 0, "t5_mute_with_stop");
      pulso(P_MR | P_STL);
      esperado(1, 1, 2, 1, 0, 1, 0, "t5_play_muted");
      esperado(5, 1, 2, 1, 1, 1, 0, "t5_count");
      pulso(P_PL);
      repeat (5) @(negedge clk);
      esperado(1, 0, 0, 0, 0, 0, 0, "t5_reset");
      reset_n = 1'b0;
      aplica(P_PL);
      @(negedge clk);
      reset_n = 1'b1;
      aplica(7'd0);
      esperado(1, 0, 0, 0, 0, 0, 0, "t5_after_reset");
      @(negedge clk);

      // 6: last track
      esperado(1, 0, 1, 0, 0, 0, 0, "t6_sel_1");
      pulso(P_SL);
      esperado(1, 0, 2, 0, 0, 0, 0, "t6_sel_2");
      pulso(P_SL);
      esperado(1, 0, 3, 0, 0, 0, 0, "t6_sel_3");
      pulso(P_SL);
`ifdef AUTO_AVANCO_EN
      esperado(1, 1, 3, 0, 0, 1, 0, "t6_play");
      esperado(9, 1, 3, 0, 2, 1, 0, "t6_tempo2");
      esperado(12, 1, 3, 0, 2, 1, 0, "t6_pre_end");
      esperado(13, 0, 0, 0, 0, 0, 1, "t6_end_last");
      esperado(14, 0, 0, 0, 0, 0, 0, "t6_fim_once");
      pulso(P_PL);
      repeat (13) @(negedge clk);
      esperado(1, 1, 0, 0, 0, 1, 0, "t6_play_f0");
      esperado(13, 1, 1, 0, 0, 1, 1, "t6_advance");
      esperado(14, 1, 1, 0, 0, 1, 0, "t6_adv_fim_clear");
      pulso(P_PL);
      repeat (13) @(negedge clk);
      repeat (10) @(negedge clk);
      esperado(1, 1, 2, 0, 0, 1, 0, "t6_cmd_beats_end");
      esperado(2, 1, 2, 0, 0, 1, 0, "t6_no_fim");
      pulso(P_SL);
      @(negedge clk);
`else
      esperado(1, 1, 3, 0, 0, 1, 0, "t6_play");
      esperado(13, 1, 3, 0, 3, 1, 0, "t6_no_end");
      esperado(29, 1, 3, 0, 7, 1, 0, "t6_tempo7");
      esperado(33, 1, 3, 0, 7, 1, 0, "t6_saturated");
      esperado(37, 1, 3, 0, 7, 1, 0, "t6_still_saturated");
      pulso(P_PL);
      repeat (36) @(negedge clk);
`endif

      for (int k = 0; k < 50 && exp_q.size() > 0; k++) @(negedge clk);
      if (exp_q.size() > 0) begin
         checks++;
         failures++;
         $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
